ro_meas_ctrl: RTL and testbench
===============================

RO_MEAS_CTRL -- requirements
Module: ro_meas_ctrl

Interface
REQ-001 Parameter WIN_W, default 16: width of the measurement-window length in clk cycles.
REQ-002 Parameter CNT_W, default 20: width of the edge-count result.
REQ-003 Parameter SETTLE, default 2: clk cycles between ro_activate rising and the start of the window.
REQ-004 clk  input  1  system clock; all state changes on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request one measurement; sampled only in IDLE.
REQ-007 abort  input  1  cancel any measurement in progress.
REQ-008 win_len  input  WIN_W  window length in cycles; latched when start is accepted.
REQ-009 ro_out  input  1  oscillator output, asynchronous to clk.
REQ-010 ro_activate  output  1  enable to the ring oscillator.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 result_valid  output  1  result available (HOLD state).
REQ-013 result_ready  input  1  consumer accepts the result.
REQ-014 result_count  output  CNT_W  ro_out rising edges counted in the window.
REQ-015 result_ovf  output  1  count saturated during the window.

Function
REQ-016 States: IDLE, ARM, MEASURE, DRAIN, HOLD; the state register is one-hot or binary, implementer's choice.
REQ-017 IDLE, start=1, win_len!=0: latch win_len, clear the counter and ovf, go to ARM next cycle.
REQ-018 IDLE, start=1, win_len==0: go directly to HOLD with count 0 and ovf 0; ro_activate is never asserted.
REQ-019 ro_activate is high exactly in ARM and MEASURE and low in all other states (a registered output).
REQ-020 ARM lasts exactly SETTLE cycles, then moves to MEASURE.
REQ-021 ro_out passes through a 2-flop synchronizer followed by a registered rising-edge detector; this gives a 3-cycle detection latency.
REQ-022 MEASURE lasts exactly the latched win_len cycles; each cycle with an edge pulse in MEASURE increments the counter by 1.
REQ-023 On reaching 2^CNT_W-1 the counter saturates and result_ovf is set; result_ovf stays set until the next accepted start.
REQ-024 DRAIN lasts 2 cycles, then moves to HOLD; edge pulses in ARM and DRAIN are not counted.
REQ-025 In HOLD, result_valid=1 and result_count/result_ovf are stable.
REQ-026 In HOLD, when result_valid & result_ready, go to IDLE next cycle and drop result_valid.
REQ-027 result_count and result_ovf keep their values in IDLE until the next accepted start.
REQ-028 start while busy is ignored; it is not queued.
REQ-029 abort=1 in ARM, MEASURE or DRAIN: go to IDLE next cycle, ro_activate low, no result_valid, counter contents undefined-but-stable.
REQ-030 abort in HOLD or IDLE has no effect.
REQ-031 abort has priority over a same-cycle window end or start.
REQ-032 The window counter counts down from the latched win_len; a win_len change during a measurement has no effect.

Reset
REQ-033 Asserting rst_n forces IDLE immediately, independent of clk.
REQ-034 Reset values: ro_activate=0, busy=0, result_valid=0, result_count=0, result_ovf=0, and the synchronizer and edge detector flops cleared.
REQ-035 Reset mid-MEASURE drops ro_activate asynchronously; after release the block waits in IDLE for start.

Verification
REQ-036 ro_out driven with a period of 6 clk (3 high/3 low), start with win_len=60 -> ro_activate high for 62 cycles, result_count=10, result_ovf=0, result_valid until ready.
REQ-037 CNT_W=4, ro_out period 4, win_len=100 -> result_count=15, result_ovf=1.
REQ-038 win_len=0 start -> result_valid one cycle after start, count 0, ro_activate never high.
REQ-039 abort at MEASURE cycle 10 -> IDLE next cycle, ro_activate=0, result_valid never set; a following start with win_len=60 gives count=10.
REQ-040 result_ready held low for 20 cycles in HOLD, plus a start pulse during HOLD -> result stable, start ignored, IDLE one cycle after ready.
REQ-041 rst_n pulsed mid-MEASURE between clock edges -> all outputs 0 immediately; the next measurement is correct.

Source files
------------

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement controller: enables the oscillator, lets it settle,
// counts synchronized ro_out rising edges over a programmable window and holds the result.
module ro_meas_ctrl #(
    parameter int WIN_W  = 16,
    parameter int CNT_W  = 20,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIN_W-1:0] win_len,
    input  logic             ro_out,
    output logic             ro_activate,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] result_count,
    output logic             result_ovf,
    output logic [2:0]       state_dbg
);

    // Handshake: the result transfers on a cycle where result_valid & result_ready;
    // result_valid is high for the whole of HOLD and the result is stable while it waits.

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_MEASURE = 3'd2,
        S_DRAIN   = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE - 1);
    localparam logic [WIN_W-1:0] DRAIN_LAST  = WIN_W'(1);
    localparam logic [WIN_W-1:0] ONE_W       = WIN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIN_W-1:0] tmr_q;
    logic [WIN_W-1:0] win_q;
    logic [CNT_W-1:0] count_q;
    logic             ovf_q;
    logic             sync1_q, sync2_q, prev_q, edge_q;
    logic             accept;

    assign accept = (state_q == S_IDLE) && start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = (win_len == '0) ? S_HOLD : S_ARM;
            end
            S_ARM: begin
                if (abort)              state_d = S_IDLE;
                else if (tmr_q == '0)   state_d = S_MEASURE;
            end
            S_MEASURE: begin
                if (abort)              state_d = S_IDLE;
                else if (tmr_q == '0)   state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)              state_d = S_IDLE;
                else if (tmr_q == '0)   state_d = S_HOLD;
            end
            S_HOLD: begin
                if (result_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            ro_activate <= 1'b0;
        end else begin
            state_q     <= state_d;
            ro_activate <= (state_d == S_ARM) || (state_d == S_MEASURE);
        end
    end

    // One down-counter times ARM, MEASURE and DRAIN in turn; it reloads on each phase change.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tmr_q <= '0;
            win_q <= '0;
        end else if (accept) begin
            tmr_q <= SETTLE_LAST;
            win_q <= win_len;
        end else begin
            case (state_q)
                S_ARM:     tmr_q <= (tmr_q == '0) ? (win_q - ONE_W) : (tmr_q - ONE_W);
                S_MEASURE: tmr_q <= (tmr_q == '0) ? DRAIN_LAST : (tmr_q - ONE_W);
                S_DRAIN:   tmr_q <= tmr_q - ONE_W;
                default:   tmr_q <= tmr_q;
            endcase
        end
    end

    // ro_out is asynchronous: two-flop synchronizer, then a registered rising-edge pulse.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= ro_out;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            edge_q  <= sync2_q & ~prev_q;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if ((state_q == S_MEASURE) && edge_q && (count_q != CNT_MAX)) begin
            count_q <= count_q + ONE_C;
            if (count_q == (CNT_MAX - ONE_C)) ovf_q <= 1'b1;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign result_valid = (state_q == S_HOLD);
    assign result_count = count_q;
    assign result_ovf   = ovf_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Directed bench for ro_meas_ctrl: a table of window/oscillator-period vectors plus
// hand-written abort, hold-stall and asynchronous-reset sequences.
module tb_ro_meas_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] win_len = '0;
    logic        ro_out = 1'b0;
    logic        result_ready = 1'b0;

    logic        ro_activate, busy, result_valid, result_ovf;
    logic [19:0] result_count;
    logic [2:0]  state_dbg;
    logic        ro_activate4, busy4, result_valid4, result_ovf4;
    logic [3:0]  result_count4;
    logic [2:0]  state_dbg4;

    int checks = 0;
    int errors = 0;
    int half = 0;
    int ph = 0;

    ro_meas_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .win_len(win_len),
        .ro_out(ro_out), .ro_activate(ro_activate), .busy(busy),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_count(result_count), .result_ovf(result_ovf), .state_dbg(state_dbg)
    );

    ro_meas_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .win_len(win_len),
        .ro_out(ro_out), .ro_activate(ro_activate4), .busy(busy4),
        .result_valid(result_valid4), .result_ready(result_ready),
        .result_count(result_count4), .result_ovf(result_ovf4), .state_dbg(state_dbg4)
    );

    // Clock / oscillator
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (half == 0) begin
                ro_out = 1'b0;
                ph = 0;
            end else begin
                ph++;
                if (ph >= half) begin
                    ph = 0;
                    ro_out = ~ro_out;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_start(input int win);
        @(negedge clk);
        start = 1'b1;
        win_len = 16'(win);
        @(negedge clk);
        start = 1'b0;
        win_len = 16'($urandom_range(1, 65535));
    endtask

    task automatic wait_valid(output int waited, output int act);
        waited = 0;
        act = 0;
        while (!result_valid && waited < 400) begin
            if (ro_activate) act++;
            waited++;
            @(negedge clk);
        end
        chk("valid_wait", 32'(result_valid), 32'd1);
    endtask

    task automatic release_result();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("valid_drop", 32'(result_valid), 32'd0);
        chk("busy_drop", 32'(busy), 32'd0);
    endtask

    typedef struct {
        int win;
        int half;
        int exp_cnt;
        int exp_act;
        int exp_wait;
        int exp_cnt4;
        int exp_ovf4;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int waited, act;
        half = v.half;
        repeat (10) @(negedge clk);
        do_start(v.win);
        wait_valid(waited, act);
        chk("act_cycles", 32'(act), 32'(v.exp_act));
        chk("wait_cycles", 32'(waited), 32'(v.exp_wait));
        chk("count", 32'(result_count), 32'(v.exp_cnt));
        chk("ovf", 32'(result_ovf), 32'd0);
        chk("count4", 32'(result_count4), 32'(v.exp_cnt4));
        chk("ovf4", 32'(result_ovf4), 32'(v.exp_ovf4));
        release_result();
        repeat (3) @(negedge clk);
        chk("count_idle", 32'(result_count), 32'(v.exp_cnt));
        chk("ovf4_idle", 32'(result_ovf4), 32'(v.exp_ovf4));
    endtask

    vec_t vecs[5];

    initial begin
        int waited, act;
        vecs[0] = '{win: 60,  half: 3, exp_cnt: 10, exp_act: 62,  exp_wait: 64,  exp_cnt4: 10, exp_ovf4: 0};
        vecs[1] = '{win: 100, half: 2, exp_cnt: 25, exp_act: 102, exp_wait: 104, exp_cnt4: 15, exp_ovf4: 1};
        vecs[2] = '{win: 0,   half: 3, exp_cnt: 0,  exp_act: 0,   exp_wait: 0,   exp_cnt4: 0,  exp_ovf4: 0};
        vecs[3] = '{win: 12,  half: 3, exp_cnt: 2,  exp_act: 14,  exp_wait: 16,  exp_cnt4: 2,  exp_ovf4: 0};
        vecs[4] = '{win: 32,  half: 1, exp_cnt: 16, exp_act: 34,  exp_wait: 36,  exp_cnt4: 15, exp_ovf4: 1};

        // Reset state
        #2;
        chk("rst_act", 32'(ro_activate), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_count", 32'(result_count), 32'd0);
        chk("rst_ovf", 32'(result_ovf), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Abort in the 10th MEASURE cycle, then a clean measurement
        half = 3;
        repeat (10) @(negedge clk);
        do_start(60);
        repeat (11) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_act", 32'(ro_activate), 32'd0);
        waited = 0;
        repeat (20) begin
            if (result_valid || ro_activate) waited++;
            @(negedge clk);
        end
        chk("abort_no_valid", 32'(waited), 32'd0);
        run_vec(vecs[0]);

        // HOLD stall: ready low 20 cycles, stray start and abort ignored
        half = 3;
        repeat (10) @(negedge clk);
        do_start(12);
        wait_valid(waited, act);
        for (int c = 0; c < 20; c++) begin
            start = (c == 5);
            win_len = 16'd7;
            abort = (c == 8);
            @(negedge clk);
            chk("hold_valid", 32'(result_valid), 32'd1);
            chk("hold_count", 32'(result_count), 32'd2);
        end
        start = 1'b0;
        abort = 1'b0;
        release_result();
        repeat (5) @(negedge clk);
        chk("no_queued_start", 32'(busy), 32'd0);
        chk("hold_count_idle", 32'(result_count), 32'd2);

        // Asynchronous reset mid-MEASURE
        repeat (5) @(negedge clk);
        do_start(60);
        repeat (12) @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst_act", 32'(ro_activate), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(result_valid), 32'd0);
        chk("arst_count", 32'(result_count), 32'd0);
        chk("arst_ovf", 32'(result_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("arst_idle", 32'(busy), 32'd0);
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
